// File: rtl/exe_mem_stage.sv
// Execute-to-memory pipeline stage: takes the ALU result bus, performs the data-memory
// access for loads/stores and presents one aligned commit packet to write-back.
//
// state | meaning
// IDLE  | no instruction held
// REQ   | memory request pending on the bus
// RSP   | waiting for the memory response
// WB    | commit packet presented to write-back
module exe_mem_stage #(
   parameter int XLEN              = 32,
   parameter int LOAD_FAULT_CAUSE  = 5,
   parameter int STORE_FAULT_CAUSE = 7
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [73:0]     in_alu,
   input  logic [4:0]      in_rd,
   input  logic [2:0]      in_funct3,
   input  logic [1:0]      in_memaccess,
   input  logic [XLEN-1:0] in_storedata,
   input  logic [XLEN-1:0] in_pc,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   output logic [XLEN-1:0] mem_req_wdata,
   output logic [3:0]      mem_req_wstrb,
   output logic            mem_req_we,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   input  logic            mem_rsp_err,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_trap,
   output logic [5:0]      wb_cause,
   output logic            wb_redirect,
   output logic [XLEN-1:0] wb_target,
   output logic [XLEN-1:0] wb_pc
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_WB} state_t;

   state_t          state_q, state_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            store_q, store_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_valid_q, req_valid_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] req_wdata_q, req_wdata_d;
   logic [3:0]      req_wstrb_q, req_wstrb_d;
   logic            req_we_q, req_we_d;
   logic            wb_valid_q, wb_valid_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            wb_trap_q, wb_trap_d;
   logic [5:0]      wb_cause_q, wb_cause_d;
   logic            wb_redirect_q, wb_redirect_d;
   logic [XLEN-1:0] wb_target_q, wb_target_d;
   logic [XLEN-1:0] wb_pc_q, wb_pc_d;

   logic            accept;
   logic [1:0]      in_type;
   logic [XLEN-1:0] in_addr;
   logic [3:0]      st_wstrb;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] load_shifted;
   logic [XLEN-1:0] load_data;

   assign in_type  = in_alu[72:71];
   assign in_addr  = in_alu[38:7];
   assign in_ready = !RST && ((state_q == S_IDLE) || (state_q == S_WB && wb_ready));
   assign accept   = in_valid && in_ready;

   assign mem_req_valid = req_valid_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_wdata = req_wdata_q;
   assign mem_req_wstrb = req_wstrb_q;
   assign mem_req_we    = req_we_q;
   assign wb_valid      = wb_valid_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign wb_trap       = wb_trap_q;
   assign wb_cause      = wb_cause_q;
   assign wb_redirect   = wb_redirect_q;
   assign wb_target     = wb_target_q;
   assign wb_pc         = wb_pc_q;

   // Store lane placement: narrow data is replicated so any byte lane selected by wstrb is valid.
   always_comb begin
      case (in_funct3[1:0])
         2'd0: begin
            st_wstrb = 4'b0001 << in_addr[1:0];
            st_wdata = {4{in_storedata[7:0]}};
         end
         2'd1: begin
            st_wstrb = 4'b0011 << in_addr[1:0];
            st_wdata = {2{in_storedata[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = in_storedata;
         end
      endcase
   end

   always_comb begin
      load_shifted = mem_rsp_data >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'd0:    load_data = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
         3'd1:    load_data = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
         3'd4:    load_data = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
         3'd5:    load_data = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
         default: load_data = load_shifted;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      rd_d          = rd_q;
      funct3_d      = funct3_q;
      store_d       = store_q;
      addr_d        = addr_q;
      pc_d          = pc_q;
      req_valid_d   = req_valid_q;
      req_addr_d    = req_addr_q;
      req_wdata_d   = req_wdata_q;
      req_wstrb_d   = req_wstrb_q;
      req_we_d      = req_we_q;
      wb_valid_d    = wb_valid_q;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      wb_trap_d     = wb_trap_q;
      wb_cause_d    = wb_cause_q;
      wb_redirect_d = wb_redirect_q;
      wb_target_d   = wb_target_q;
      wb_pc_d       = wb_pc_q;

      case (state_q)
         S_REQ: begin
            if (mem_req_ready) begin
               state_d     = S_RSP;
               req_valid_d = 1'b0;
               req_addr_d  = '0;
               req_wdata_d = '0;
               req_wstrb_d = '0;
               req_we_d    = 1'b0;
            end
         end
         S_RSP: begin
            if (mem_rsp_valid) begin
               state_d       = S_WB;
               wb_valid_d    = 1'b1;
               wb_pc_d       = pc_q;
               wb_redirect_d = 1'b0;
               if (mem_rsp_err) begin
                  wb_trap_d   = 1'b1;
                  wb_cause_d  = store_q ? 6'(STORE_FAULT_CAUSE) : 6'(LOAD_FAULT_CAUSE);
                  wb_target_d = addr_q;
                  wb_rd_d     = '0;
                  wb_data_d   = '0;
               end else begin
                  wb_trap_d   = 1'b0;
                  wb_cause_d  = '0;
                  wb_target_d = '0;
                  wb_rd_d     = store_q ? 5'd0 : rd_q;
                  wb_data_d   = store_q ? '0 : load_data;
               end
            end
         end
         S_WB: begin
            if (wb_ready) begin
               state_d       = S_IDLE;
               wb_valid_d    = 1'b0;
               wb_rd_d       = '0;
               wb_data_d     = '0;
               wb_trap_d     = 1'b0;
               wb_cause_d    = '0;
               wb_redirect_d = 1'b0;
               wb_target_d   = '0;
               wb_pc_d       = '0;
            end
         end
         default: ;
      endcase

      // A new packet overrides the WB drain above; invalid ALU packets are swallowed here.
      if (accept) begin
         rd_d     = in_rd;
         funct3_d = in_funct3;
         store_d  = (in_memaccess == 2'd1);
         addr_d   = in_addr;
         pc_d     = in_pc;
         if (in_alu[73]) begin
            if (in_type == 2'd3) begin
               state_d       = S_WB;
               wb_valid_d    = 1'b1;
               wb_trap_d     = 1'b1;
               wb_cause_d    = in_alu[6:1];
               wb_target_d   = in_addr;
               wb_redirect_d = 1'b0;
               wb_rd_d       = '0;
               wb_data_d     = '0;
               wb_pc_d       = in_pc;
            end else if (in_type == 2'd0 && !in_memaccess[1]) begin
               state_d     = S_REQ;
               req_valid_d = 1'b1;
               req_addr_d  = {in_addr[XLEN-1:2], 2'b00};
               req_we_d    = in_memaccess[0];
               req_wstrb_d = in_memaccess[0] ? st_wstrb : 4'b0000;
               req_wdata_d = in_memaccess[0] ? st_wdata : '0;
            end else begin
               state_d       = S_WB;
               wb_valid_d    = 1'b1;
               wb_trap_d     = 1'b0;
               wb_cause_d    = '0;
               wb_data_d     = in_alu[70:39];
               wb_rd_d       = in_rd;
               wb_redirect_d = in_alu[0];
               wb_target_d   = in_addr;
               wb_pc_d       = in_pc;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         rd_q          <= '0;
         funct3_q      <= '0;
         store_q       <= 1'b0;
         addr_q        <= '0;
         pc_q          <= '0;
         req_valid_q   <= 1'b0;
         req_addr_q    <= '0;
         req_wdata_q   <= '0;
         req_wstrb_q   <= '0;
         req_we_q      <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         wb_trap_q     <= 1'b0;
         wb_cause_q    <= '0;
         wb_redirect_q <= 1'b0;
         wb_target_q   <= '0;
         wb_pc_q       <= '0;
      end else begin
         state_q       <= state_d;
         rd_q          <= rd_d;
         funct3_q      <= funct3_d;
         store_q       <= store_d;
         addr_q        <= addr_d;
         pc_q          <= pc_d;
         req_valid_q   <= req_valid_d;
         req_addr_q    <= req_addr_d;
         req_wdata_q   <= req_wdata_d;
         req_wstrb_q   <= req_wstrb_d;
         req_we_q      <= req_we_d;
         wb_valid_q    <= wb_valid_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         wb_trap_q     <= wb_trap_d;
         wb_cause_q    <= wb_cause_d;
         wb_redirect_q <= wb_redirect_d;
         wb_target_q   <= wb_target_d;
         wb_pc_q       <= wb_pc_d;
      end
   end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage: stimulus pushes expected commit packets into a queue,
// an independent negedge monitor pops and compares on every write-back handshake.
module tb_exe_mem_stage;
   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready;
   logic [73:0] in_alu;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [1:0]  in_memaccess;
   logic [31:0] in_storedata, in_pc;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_req_we;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_trap;
   logic [5:0]  wb_cause;
   logic        wb_redirect;
   logic [31:0] wb_target, wb_pc;

   exe_mem_stage #(.XLEN(32), .LOAD_FAULT_CAUSE(5), .STORE_FAULT_CAUSE(7)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu), .in_rd(in_rd),
      .in_funct3(in_funct3), .in_memaccess(in_memaccess), .in_storedata(in_storedata), .in_pc(in_pc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_we(mem_req_we),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_trap(wb_trap), .wb_cause(wb_cause), .wb_redirect(wb_redirect),
      .wb_target(wb_target), .wb_pc(wb_pc)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        trap;
      logic [5:0]  cause;
      logic        redirect;
      logic [31:0] target;
      logic [31:0] pc;
      int          cyc;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [73:0] mk_alu(input logic v, input logic [1:0] t, input logic [31:0] res,
                                          input logic [31:0] addr, input logic [5:0] cause, input logic redir);
      return {v, t, res, addr, cause, redir};
   endfunction

   function automatic void push_exp(input logic [4:0] rd, input logic [31:0] data, input logic trap,
                                    input logic [5:0] cause, input logic redir, input logic [31:0] target,
                                    input logic [31:0] pc, input int c);
      wb_exp_t e;
      e.rd = rd; e.data = data; e.trap = trap; e.cause = cause;
      e.redirect = redir; e.target = target; e.pc = pc; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   // Monitor: compares every write-back handshake against the head of the scoreboard.
   always @(negedge CLK) begin : monitor
      wb_exp_t e;
      if (!RST && wb_valid && wb_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_unexpected actual rd=%0d data=%h trap=%0b required no packet", wb_rd, wb_data, wb_trap);
         end else begin
            e = exp_q.pop_front();
            chk("wb_packet", 128'({wb_rd, wb_data, wb_trap, wb_cause, wb_redirect, wb_target, wb_pc}),
                128'({e.rd, e.data, e.trap, e.cause, e.redirect, e.target, e.pc}));
            if (e.cyc >= 0) chk("wb_latency", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic send_pkt(input logic [73:0] alu, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] ma, input logic [31:0] sd, input logic [31:0] pc, output int acc);
      int n = 0;
      in_alu = alu; in_rd = rd; in_funct3 = f3; in_memaccess = ma; in_storedata = sd; in_pc = pc;
      in_valid = 1'b1;
      acc = -1;
      while (acc < 0 && n < 50) begin
         @(negedge CLK);
         if (in_ready) acc = cyc;
         @(posedge CLK); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("accepted", 128'(acc >= 0), 128'(1));
   endtask

   task automatic mem_serve(input int stall, input int rsp_delay, input logic [31:0] e_addr,
                            input logic [31:0] e_wdata, input logic [3:0] e_wstrb, input logic e_we,
                            input logic [31:0] rdata, input logic err);
      for (int i = 0; i <= stall; i++) begin
         if (i == stall) mem_req_ready = 1'b1;
         @(negedge CLK);
         chk("mem_req", 128'({mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_we}),
             128'({1'b1, e_addr, e_wdata, e_wstrb, e_we}));
         @(posedge CLK); #1;
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_delay; i++) begin
         @(negedge CLK);
         chk("req_dropped", 128'({mem_req_valid, wb_valid}), 128'(0));
         @(posedge CLK); #1;
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = rdata; mem_rsp_err = err;
      @(posedge CLK); #1;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("drain", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem"}, 128'({in_ready, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_we}), 128'(0));
      chk({tag, "_wb"}, 128'({wb_valid, wb_rd, wb_data, wb_trap, wb_cause, wb_redirect, wb_target, wb_pc}), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1;
      RST = 1'b1; in_valid = 1'b0; in_alu = '0; in_rd = '0; in_funct3 = '0; in_memaccess = '0;
      in_storedata = '0; in_pc = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_data = '0; mem_rsp_err = 1'b0; wb_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      @(negedge CLK);
      check_all_zero("reset");
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("idle_ready", 128'(in_ready), 128'(1));
      @(posedge CLK); #1;

      // Back-to-back non-memory packets
      send_pkt(mk_alu(1, 2'd2, 32'h0000_1234, 32'h0, 6'd0, 1'b0), 5'd5, 3'd0, 2'd2, 32'h0, 32'h100, a0);
      push_exp(5'd5, 32'h0000_1234, 1'b0, 6'd0, 1'b0, 32'h0, 32'h100, a0 + 1);
      send_pkt(mk_alu(1, 2'd1, 32'hCAFE_0000, 32'h400, 6'd0, 1'b1), 5'd7, 3'd0, 2'd3, 32'h0, 32'h104, a1);
      push_exp(5'd7, 32'hCAFE_0000, 1'b0, 6'd0, 1'b1, 32'h400, 32'h104, a1 + 1);
      chk("no_bubble", 128'(a1 - a0), 128'(1));
      wait_drain();

      // Loads with alignment and extension
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h1003, 6'd0, 1'b0), 5'd3, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h200, a0);
      push_exp(5'd3, 32'hFFFF_FF80, 1'b0, 6'd0, 1'b0, 32'h0, 32'h200, -1);
      mem_serve(0, 0, 32'h1000, 32'h0, 4'b0000, 1'b0, 32'h80AA_BBCC, 1'b0);
      wait_drain();
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h1003, 6'd0, 1'b0), 5'd3, 3'd4, 2'd0, 32'h0, 32'h204, a0);
      push_exp(5'd3, 32'h0000_0080, 1'b0, 6'd0, 1'b0, 32'h0, 32'h204, -1);
      mem_serve(0, 0, 32'h1000, 32'h0, 4'b0000, 1'b0, 32'h80AA_BBCC, 1'b0);
      wait_drain();
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h1002, 6'd0, 1'b0), 5'd12, 3'd1, 2'd0, 32'h0, 32'h208, a0);
      push_exp(5'd12, 32'hFFFF_80AA, 1'b0, 6'd0, 1'b0, 32'h0, 32'h208, -1);
      mem_serve(1, 2, 32'h1000, 32'h0, 4'b0000, 1'b0, 32'h80AA_BBCC, 1'b0);
      wait_drain();
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h1000, 6'd0, 1'b0), 5'd13, 3'd2, 2'd0, 32'h0, 32'h20C, a0);
      push_exp(5'd13, 32'h80AA_BBCC, 1'b0, 6'd0, 1'b0, 32'h0, 32'h20C, -1);
      mem_serve(0, 0, 32'h1000, 32'h0, 4'b0000, 1'b0, 32'h80AA_BBCC, 1'b0);
      wait_drain();

      // Stores: halfword with request stall, byte lane replication
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h2002, 6'd0, 1'b0), 5'd9, 3'd1, 2'd1, 32'hDEAD_BEEF, 32'h300, a0);
      push_exp(5'd0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0, 32'h300, -1);
      mem_serve(3, 0, 32'h2000, 32'hBEEF_BEEF, 4'b1100, 1'b1, 32'h0, 1'b0);
      wait_drain();
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h2001, 6'd0, 1'b0), 5'd9, 3'd0, 2'd1, 32'h1234_5678, 32'h304, a0);
      push_exp(5'd0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0, 32'h304, -1);
      mem_serve(0, 1, 32'h2000, 32'h7878_7878, 4'b0010, 1'b1, 32'h0, 1'b0);
      wait_drain();

      // Access faults
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h3000, 6'd0, 1'b0), 5'd4, 3'd2, 2'd0, 32'h0, 32'h400, a0);
      push_exp(5'd0, 32'h0, 1'b1, 6'd5, 1'b0, 32'h3000, 32'h400, -1);
      mem_serve(0, 0, 32'h3000, 32'h0, 4'b0000, 1'b0, 32'h5555_5555, 1'b1);
      wait_drain();
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h3004, 6'd0, 1'b0), 5'd4, 3'd2, 2'd1, 32'hA5A5_0F0F, 32'h404, a0);
      push_exp(5'd0, 32'h0, 1'b1, 6'd7, 1'b0, 32'h3004, 32'h404, -1);
      mem_serve(0, 0, 32'h3004, 32'hA5A5_0F0F, 4'b1111, 1'b1, 32'h0, 1'b1);
      wait_drain();

      // ALU trap held under write-back backpressure
      wb_ready = 1'b0;
      send_pkt(mk_alu(1, 2'd3, 32'h99, 32'h500, 6'd4, 1'b1), 5'd8, 3'd0, 2'd0, 32'h0, 32'h500, a0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("trap_hold", 128'({wb_valid, wb_trap, wb_cause, wb_target, wb_rd, in_ready, mem_req_valid}),
             128'({1'b1, 1'b1, 6'd4, 32'h500, 5'd0, 1'b0, 1'b0}));
         @(posedge CLK); #1;
      end
      push_exp(5'd0, 32'h0, 1'b1, 6'd4, 1'b0, 32'h500, 32'h500, -1);
      wb_ready = 1'b1;
      wait_drain();

      // Type 0 without bus access, then an invalid (dropped) packet
      send_pkt(mk_alu(1, 2'd0, 32'h55AA, 32'h600, 6'd0, 1'b0), 5'd10, 3'd2, 2'd2, 32'h0, 32'h600, a0);
      push_exp(5'd10, 32'h0000_55AA, 1'b0, 6'd0, 1'b0, 32'h600, 32'h600, a0 + 1);
      wait_drain();
      send_pkt(mk_alu(0, 2'd2, 32'h777, 32'h0, 6'd0, 1'b0), 5'd11, 3'd0, 2'd2, 32'h0, 32'h604, a0);
      @(negedge CLK);
      chk("dropped", 128'({wb_valid, mem_req_valid, in_ready}), 128'(3'b001));
      @(posedge CLK); #1;

      // Reset while waiting for a response; the late response must be ignored
      send_pkt(mk_alu(1, 2'd0, 32'h0, 32'h4000, 6'd0, 1'b0), 5'd6, 3'd2, 2'd0, 32'h0, 32'h700, a0);
      mem_req_ready = 1'b1;
      @(negedge CLK);
      chk("rst_req", 128'({mem_req_valid, mem_req_addr}), 128'({1'b1, 32'h4000}));
      @(posedge CLK); #1;
      mem_req_ready = 1'b0;
      @(negedge CLK);
      chk("rst_in_rsp", 128'({mem_req_valid, wb_valid, in_ready}), 128'(0));
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check_all_zero("mid_reset");
      @(posedge CLK); #1;
      RST = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
      @(posedge CLK); #1;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("late_rsp", 128'({wb_valid, mem_req_valid, in_ready}), 128'(3'b001));
         @(posedge CLK); #1;
      end

      chk("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Pipeline stage directly downstream of the reduced_fn_alu combinational ALU.
- Accepts the 74-bit ALU result bus plus side-band operands over a valid/ready handshake.
- Performs the data-memory access for loads and stores over a request/response bus.
- Presents one aligned, sign-extended write-back/commit packet per instruction to the write-back stage.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- LOAD_FAULT_CAUSE, 5, trap cause reported when a load response has an error.
- STORE_FAULT_CAUSE, 7, trap cause reported when a store response has an error.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  stage can accept a packet
- in_alu  in  74  ALU bus: [73] valid, [72:71] commit type, [70:39] result, [38:7] effective address/target, [6:1] cause, [0] redirect
- in_rd  in  5  destination register
- in_funct3  in  3  load/store size and sign
- in_memaccess  in  2  0 = load, 1 = store, 2/3 = no bus access
- in_storedata  in  32  store source operand
- in_pc  in  32  instruction PC
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte enables
- mem_req_we  out  1  1 = store
- mem_rsp_valid  in  1  response valid (one-cycle pulse)
- mem_rsp_data  in  32  read data
- mem_rsp_err  in  1  access fault
- wb_valid  out  1  commit packet valid
- wb_ready  in  1  write-back accepts packet
- wb_rd  out  5  destination register; 0 means no write
- wb_data  out  32  write-back data
- wb_trap  out  1  instruction traps
- wb_cause  out  6  trap cause
- wb_redirect  out  1  redirect fetch to wb_target
- wb_target  out  32  redirect target / faulting address
- wb_pc  out  32  instruction PC

Behaviour:
- FSM states:
  - IDLE: no instruction held.
  - REQ: memory request pending.
  - RSP: waiting for the memory response.
  - WB: commit packet presented.
- Reset (RST=1 at a clock edge):
  - State goes to IDLE; all outputs are 0.
  - In-flight transactions are abandoned. Responses arriving afterwards are ignored, because responses are only sampled in RSP.
- in_ready = (state==IDLE) || (state==WB && wb_ready). This permits back-to-back acceptance with zero bubble.
- On accept (in_valid && in_ready), latch all inputs, then branch on commit type and memaccess:
  - Type 0 with memaccess 0/1: next state REQ.
  - Type 3: next state WB with wb_trap=1, wb_cause=in_alu[6:1], wb_target=in_alu[38:7], wb_redirect=0, wb_rd=0.
  - Type 1/2, or type 0 with memaccess 2/3: next state WB with wb_data=result, wb_rd=in_rd, wb_redirect=in_alu[0], wb_target=in_alu[38:7].
  - in_alu[73]=0 while in_valid: packet is dropped (accepted, nothing emitted).
- REQ:
  - mem_req_valid=1, and addr/wdata/wstrb/we stay stable until mem_req_ready; the handshake cycle moves to RSP.
  - Byte enables: funct3[1:0]=0 gives wstrb 4'b0001<<a[1:0]; =1 gives 4'b0011<<a[1:0]; =2 or 3 gives 4'b1111.
  - Store data lanes: byte replicated x4, half replicated x2, word as is.
  - Loads drive we=0, wstrb=0.
- RSP:
  - mem_rsp_valid with err: trap with LOAD_FAULT_CAUSE or STORE_FAULT_CAUSE, wb_target=effective address, wb_rd=0.
  - mem_rsp_valid without err, load: shift by a[1:0]*8, then extend per funct3 (0 LB sign, 1 LH sign, 2 LW, 4 LBU zero, 5 LHU zero).
  - mem_rsp_valid without err, store: wb_rd=0, wb_data=0.
  - Next state is WB; response latency is unbounded.
- WB:
  - wb_* is held stable while wb_valid && !wb_ready.
  - Handshake goes to IDLE, or directly loads the new packet if one is accepted in the same cycle.
- Minimum latency:
  - Non-memory: wb_valid in the cycle after accept.
  - Memory: accept → REQ (+1) → RSP (+1 with ready) → WB (+1 after rsp).

Test Plan:
- ALU type 2, result 0x0000_1234, rd=5, wb_ready=1 → wb_valid next cycle, wb_rd=5, wb_data=0x1234, wb_trap=0; consecutive packets issue with no bubble.
- LB from addr 0x1003, mem_rsp_data 0x80AA_BBCC → mem_req_addr=0x1000, wstrb=0, wb_data=0xFFFF_FF80; LBU to the same address → 0x0000_0080.
- SH to 0x2002, storedata 0xDEAD_BEEF, mem_req_ready low 3 cycles → request held stable, wstrb=4'b1100, wdata=0xBEEF_BEEF; completion gives wb_rd=0.
- Load response with mem_rsp_err=1, addr 0x3000 → wb_trap=1, wb_cause=5, wb_target=0x3000, wb_rd=0.
- Type 3 packet, cause 6'd4 → wb_trap=1, wb_cause=4, no mem_req_valid; wb_ready held low 4 cycles → outputs stable and in_ready=0.
- RST asserted while in RSP, then a late mem_rsp_valid → stays IDLE, all outputs 0, no wb_valid.
